// File: rtl/ch_capture.sv
`timescale 1ns/1ps
// ch_capture: one logic-analyzer channel. Synchronizes the AFE comparator pair,
// decimates, tracks level with hysteresis and writes a circular pre/post-trigger capture.
module ch_capture #(
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clk400MHz,
  input  logic                  rst_n,
  input  logic                  CH_L,
  input  logic                  CH_H,
  input  logic                  arm,
  input  logic [1:0]            trig_cfg,
  input  logic [DEPTH_LOG2-1:0] trig_pos,
  input  logic [3:0]            decimator,
  output logic                  we,
  output logic [DEPTH_LOG2-1:0] waddr,
  output logic [1:0]            wdata,
  output logic                  armed,
  output logic                  triggered,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  capture_done,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                state;
  logic [2:0]            sync_l;
  logic [2:0]            sync_h;
  logic [1:0]            sample;
  logic [14:0]           dec_cnt;
  logic [14:0]           dec_mask;
  logic                  strobe;
  logic [1:0]            cfg_q;
  logic [DEPTH_LOG2-1:0] tp_q;
  logic [3:0]            dec_q;
  logic                  lvl_hi;
  logic                  is_hi;
  logic                  is_lo;
  logic                  rise;
  logic                  fall;
  logic                  hit;
  logic                  capturing;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic [DEPTH_LOG2:0]   scount;
  logic [DEPTH_LOG2:0]   scount_inc;
  logic [DEPTH_LOG2:0]   thr;

  assign sample    = {sync_h[2], sync_l[2]};
  assign dec_mask  = ~(15'h7fff << dec_q);
  assign strobe    = (dec_cnt & dec_mask) == 15'd0;
  assign is_hi     = (sample == 2'b01);
  assign is_lo     = (sample == 2'b10);
  assign rise      = strobe & ~lvl_hi & is_hi;
  assign fall      = strobe & lvl_hi & is_lo;
  assign capturing = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
  assign scount_inc = (scount == FULL) ? FULL : scount + 1'b1;
  assign thr       = FULL - {1'b0, tp_q};
  assign fsm_state = state;

  always_comb begin
    hit = 1'b0;
    case (cfg_q)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = strobe;
    endcase
  end

  // Three flops per comparator; nothing downstream looks at the first two stages.
  always_ff @(posedge clk400MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_l <= 3'b000;
      sync_h <= 3'b000;
    end else begin
      sync_l <= {sync_l[1:0], CH_L};
      sync_h <= {sync_h[1:0], CH_H};
    end
  end

  always_ff @(posedge clk400MHz or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= 15'd0;
    end else if (arm) begin
      dec_cnt <= 15'd0;
    end else begin
      dec_cnt <= dec_cnt + 15'd1;
    end
  end

  // Hysteresis: MID and the illegal 00 code leave the tracked level unchanged.
  always_ff @(posedge clk400MHz or negedge rst_n) begin
    if (!rst_n) begin
      lvl_hi <= 1'b0;
    end else if (strobe) begin
      if (is_hi) begin
        lvl_hi <= 1'b1;
      end else if (is_lo) begin
        lvl_hi <= 1'b0;
      end
    end
  end

  // we is a one-cycle strobe registered together with waddr/wdata; waddr holds
  // the address of the write being presented whenever we is high.
  always_ff @(posedge clk400MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= 2'b00;
      wptr         <= '0;
      scount       <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      cfg_q        <= 2'b00;
      tp_q         <= '0;
      dec_q        <= 4'd0;
    end else begin
      we <= 1'b0;
      if (arm) begin
        state        <= PREFILL;
        armed        <= 1'b1;
        triggered    <= 1'b0;
        capture_done <= 1'b0;
        wptr         <= '0;
        waddr        <= '0;
        scount       <= '0;
        cfg_q        <= trig_cfg;
        tp_q         <= trig_pos;
        dec_q        <= decimator;
      end else begin
        if (capturing && strobe) begin
          we     <= 1'b1;
          wdata  <= sample;
          waddr  <= wptr;
          wptr   <= wptr + 1'b1;
          scount <= scount_inc;
        end
        case (state)
          PREFILL: begin
            if (strobe && (scount_inc >= thr)) begin
              state <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (hit) begin
              trig_addr <= wptr;
              triggered <= 1'b1;
              post_cnt  <= tp_q;
              if (tp_q == '0) begin
                state        <= DONE;
                armed        <= 1'b0;
                capture_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (strobe) begin
              if (post_cnt <= 1) begin
                state        <= DONE;
                armed        <= 1'b0;
                capture_done <= 1'b1;
              end else begin
                post_cnt <= post_cnt - 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ch_capture.sv
`timescale 1ns/1ps
// Bench for ch_capture: trigger vector table with an expected-result queue,
// plus hand-written long captures, reset and re-arm sequences.
module tb_ch_capture;

  localparam int DL    = 13;
  localparam int DEPTH = 1 << DL;
  localparam logic [1:0] LO  = 2'b10;
  localparam logic [1:0] HI  = 2'b01;
  localparam logic [1:0] MID = 2'b11;
  localparam logic [1:0] ILL = 2'b00;

  logic          clk400MHz = 1'b0;
  logic          rst_n;
  logic          CH_L, CH_H, arm;
  logic [1:0]    trig_cfg;
  logic [DL-1:0] trig_pos;
  logic [3:0]    decimator;
  logic          we;
  logic [DL-1:0] waddr;
  logic [1:0]    wdata;
  logic          armed, triggered, capture_done;
  logic [DL-1:0] trig_addr;
  logic [2:0]    fsm_state;

  ch_capture #(.DEPTH_LOG2(DL)) dut (
    .clk400MHz(clk400MHz), .rst_n(rst_n), .CH_L(CH_L), .CH_H(CH_H), .arm(arm),
    .trig_cfg(trig_cfg), .trig_pos(trig_pos), .decimator(decimator),
    .we(we), .waddr(waddr), .wdata(wdata), .armed(armed), .triggered(triggered),
    .trig_addr(trig_addr), .capture_done(capture_done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #1.25 clk400MHz = ~clk400MHz;

  int cyc = 0;
  initial forever begin
    @(posedge clk400MHz);
    cyc = cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_fail = 0;
  int            wr_cnt = 0;
  int            addr_err = 0;
  int            per_err = 0;
  int            last_wr = 0;
  int            exp_per = 1;
  int            arm_cyc = 0;
  logic [DL-1:0] exp_addr = '0;
  logic [1:0]    mem [DEPTH];
  logic [DL:0]   exp_q [$];

  // Write monitor: address continuity (with wrap), strobe spacing, shadow buffer.
  initial forever begin
    @(negedge clk400MHz);
    if (rst_n === 1'b1 && we === 1'b1) begin
      if (waddr !== exp_addr) addr_err++;
      exp_addr = exp_addr + 1'b1;
      if (wr_cnt > 0 && (cyc - last_wr) != exp_per) per_err++;
      last_wr = cyc;
      wr_cnt++;
      mem[waddr] = wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] s);
    {CH_H, CH_L} = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk400MHz);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] cfg, input logic [DL-1:0] tp, input logic [3:0] dec);
    @(negedge clk400MHz);
    #1;
    trig_cfg  = cfg;
    trig_pos  = tp;
    decimator = dec;
    arm       = 1'b1;
    wr_cnt    = 0;
    addr_err  = 0;
    per_err   = 0;
    exp_addr  = '0;
    exp_per   = 1 << dec;
    arm_cyc   = cyc + 1;
    @(negedge clk400MHz);
    #1;
    arm = 1'b0;
  endtask

  // Go to just after the negedge following clock edge t (edge 0 = arm edge).
  task automatic wait_to(input int t);
    do @(negedge clk400MHz); while (cyc < arm_cyc + t);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (capture_done !== 1'b1 && n < bound) begin
      @(negedge clk400MHz);
      n++;
    end
    #1;
    check("capture_done_seen", capture_done, 1'b1);
  endtask

  // ---------------- trigger vector table ----------------
  typedef struct {
    string           name;
    logic [1:0]      cfg;
    logic [3:0]      dec;
    logic [1:0]      pre;
    logic [0:7][1:0] seq;
    logic            exp_trig;
    int              exp_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n0;
    logic [DL:0]   e;
    logic [DL-1:0] ea;

    // Samples 0..3 hold pre (sample 0 fills PREFILL), seq[j] becomes sample 4+j.
    vecs[0] = '{"v_rise_mid_glitch", 2'b00, 4'd0, LO, {LO, MID, MID, MID, LO, MID, HI, HI}, 1'b1, 10};
    vecs[1] = '{"v_fall",            2'b01, 4'd0, HI, {HI, MID, LO, LO, LO, LO, LO, LO},    1'b1, 6};
    vecs[2] = '{"v_any_fall_dec1",   2'b10, 4'd1, HI, {HI, HI, MID, LO, LO, LO, LO, LO},    1'b1, 7};
    vecs[3] = '{"v_rise_ill_dec2",   2'b00, 4'd2, HI, {HI, LO, MID, ILL, HI, HI, HI, HI},   1'b1, 8};
    vecs[4] = '{"v_rise_none_mid",   2'b00, 4'd0, LO, {MID, ILL, MID, MID, ILL, MID, ILL, MID}, 1'b0, 0};
    vecs[5] = '{"v_fall_skip_rise",  2'b01, 4'd0, LO, {LO, HI, HI, MID, LO, LO, LO, LO},    1'b1, 8};
    vecs[6] = '{"v_force",           2'b11, 4'd0, LO, {LO, LO, LO, LO, LO, LO, LO, LO},     1'b1, 1};
    vecs[7] = '{"v_rise_none_dec3",  2'b00, 4'd3, HI, {HI, HI, HI, HI, HI, HI, HI, HI},     1'b0, 0};
    vecs[8] = '{"v_any_rise",        2'b10, 4'd0, LO, {LO, ILL, MID, HI, HI, HI, HI, HI},   1'b1, 7};

    // ---------------- reset state ----------------
    rst_n = 1'b0; arm = 1'b0; trig_cfg = 2'b00; trig_pos = '0; decimator = 4'd0;
    set_in(LO);
    #3;
    check("reset_ctrl", {we, armed, triggered, capture_done, fsm_state}, 7'd0);
    check("reset_addr", {waddr, trig_addr}, 26'd0);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("idle_no_write", {fsm_state, wr_cnt[7:0]}, 11'd0);

    // ---------------- long capture, rising trigger ----------------
    do_arm(2'b00, 13'd4096, 4'd0);
    wait_to(4997);
    set_in(HI);
    wait_done(12000);
    check("c1_total_writes", wr_cnt, 9097);
    check("c1_trig_addr", trig_addr, 5000);
    check("c1_done_state", {fsm_state, armed, triggered}, {3'd4, 1'b0, 1'b1});
    check("c1_done_with_last_write", cyc - last_wr, 0);
    check("c1_addr_seq", addr_err, 0);
    check("c1_strobe_spacing", per_err, 0);
    check("c1_data_around_trig", {mem[4999], mem[5000]}, {LO, HI});
    idle(40);
    check("c1_no_write_in_done", wr_cnt, 9097);

    // ---------------- prefill edge ignored, re-arm from DONE ----------------
    set_in(LO);
    idle(5);
    do_arm(2'b00, 13'd8000, 4'd0);
    check("rearm_from_done", {fsm_state, triggered, capture_done, armed, waddr},
          {3'd1, 1'b0, 1'b0, 1'b1, 13'd0});
    wait_to(97);
    set_in(HI);
    wait_to(147);
    set_in(LO);
    wait_to(200);
    check("c2_no_prefill_trig", {fsm_state, triggered}, {3'd2, 1'b0});
    wait_to(297);
    set_in(HI);
    wait_to(320);
    check("c2_trig", {fsm_state, triggered, trig_addr}, {3'd3, 1'b1, 13'd300});
    check("c2_data_around_trig", {mem[299], mem[300]}, {LO, HI});
    check("c2_addr_seq", addr_err, 0);
    do_arm(2'b00, 13'd8000, 4'd0);
    check("rearm_mid_post", {fsm_state, triggered, capture_done, armed, waddr},
          {3'd1, 1'b0, 1'b0, 1'b1, 13'd0});
    idle(5);
    check("rearm_restart_writes", {wr_cnt[7:0], addr_err[7:0]}, {8'd5, 8'd0});

    // ---------------- table vectors ----------------
    for (int i = 0; i < 9; i++) begin
      int p;
      p = 1 << vecs[i].dec;
      set_in(vecs[i].pre);
      idle(5);
      ea = vecs[i].exp_addr[DL-1:0];
      exp_q.push_back({vecs[i].exp_trig, vecs[i].exp_trig ? ea : {DL{1'b0}}});
      do_arm(vecs[i].cfg, 13'd8191, vecs[i].dec);
      for (int j = 0; j < 8; j++) begin
        wait_to((4 + j) * p - 3);
        set_in(vecs[i].seq[j]);
      end
      wait_to(12 * p + 6);
      e = exp_q.pop_front();
      check(vecs[i].name, {armed, triggered, triggered ? trig_addr : {DL{1'b0}}}, {1'b1, e});
    end

    // ---------------- reset during POST ----------------
    set_in(LO);
    idle(5);
    do_arm(2'b11, 13'd8191, 4'd0);
    wait_to(20);
    check("c3_in_post", {fsm_state, triggered}, {3'd3, 1'b1});
    rst_n = 1'b0;
    #0.1;
    check("c3_async_ctrl", {we, armed, triggered, capture_done, fsm_state}, 7'd0);
    check("c3_async_addr", {waddr, trig_addr}, 26'd0);
    idle(3);
    rst_n = 1'b1;
    n0 = wr_cnt;
    idle(50);
    check("c3_idle_after_release", {fsm_state, we}, 4'd0);
    check("c3_no_write_after_release", wr_cnt - n0, 0);

    // ---------------- decimate by 8, wrap, forced trigger with trig_pos=0 ----------------
    do_arm(2'b11, 13'd0, 4'd3);
    wait_done(70000);
    check("c4_total_writes", wr_cnt, 8193);
    check("c4_trig_addr_wrapped", trig_addr, 0);
    check("c4_done_with_last_write", cyc - last_wr, 0);
    check("c4_addr_seq_wrap", addr_err, 0);
    check("c4_strobe_every_8", per_err, 0);
    check("c4_done_state", {fsm_state, armed, triggered}, {3'd4, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ch_capture.md
CH_CAPTURE -- requirements
Module: ch_capture

Interface
REQ-001 Parameter: DEPTH_LOG2, default 13, meaning capture buffer address width (2^DEPTH_LOG2 = 8192 entries).
REQ-002 clk400MHz  input  1  sample clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 CH_L  input  1  low comparator from the AFE channel, asynchronous: 1 = signal >= VIL.
REQ-005 CH_H  input  1  high comparator from the AFE channel, asynchronous: 1 = signal < VIH.
REQ-006 arm  input  1  one-cycle pulse that starts a capture.
REQ-007 trig_cfg  input  2  trigger type: 00 rising, 01 falling, 10 any edge, 11 force.
REQ-008 trig_pos  input  DEPTH_LOG2  number of samples stored after the trigger sample.
REQ-009 decimator  input  4  sample every 2^decimator clocks (0..15).
REQ-010 we  output  1  buffer write strobe.
REQ-011 waddr  output  DEPTH_LOG2  buffer write address.
REQ-012 wdata  output  2  stored sample, {CH_H_sync, CH_L_sync}.
REQ-013 armed  output  1  high in PREFILL, WAIT_TRIG and POST.
REQ-014 triggered  output  1  high from the trigger sample until the next arm.
REQ-015 trig_addr  output  DEPTH_LOG2  waddr of the trigger sample.
REQ-016 capture_done  output  1  high in DONE.

Function
REQ-017 CH_L and CH_H SHALL each pass through a 3-flop synchronizer; all downstream logic uses only the third-stage values.
REQ-018 Decimation counter: free-running 15-bit counter, cleared on arm; the sample strobe SHALL fire when the low `decimator` bits are all 0; decimator=0 gives a strobe every clock.
REQ-019 Level tracker: {H,L}=01 is HIGH, 10 is LOW, 11 is MID; 00 is illegal and is treated as MID; the tracker changes only on HIGH or LOW (hysteresis), updates only on strobes, and resets to LOW.
REQ-020 Edges: rising = tracker LOW -> HIGH on a strobe; falling = HIGH -> LOW; MID samples never create an edge; a LOW, MID, HIGH sequence is one rising edge, reported on the HIGH sample.
REQ-021 FSM states: IDLE, PREFILL, WAIT_TRIG, POST, DONE; arm in any state SHALL go to PREFILL and clear waddr, the sample count, triggered and capture_done.
REQ-022 In PREFILL, WAIT_TRIG and POST, every strobe SHALL assert we for exactly one cycle, with wdata = current sync sample; waddr increments after each write and wraps from 2^DEPTH_LOG2-1 to 0.
REQ-023 Sample count: saturates at 2^DEPTH_LOG2; PREFILL -> WAIT_TRIG when count >= 2^DEPTH_LOG2 - trig_pos.
REQ-024 In WAIT_TRIG, a matching edge (or any strobe when trig_cfg=11) SHALL latch trig_addr=waddr of that write, set triggered, load the post counter with trig_pos, and go to POST.
REQ-025 POST SHALL decrement on each strobe and go to DONE after trig_pos further writes; trig_pos=0 goes to DONE directly after the trigger write.
REQ-026 Edges during PREFILL SHALL be ignored; they update the tracker only.
REQ-027 DONE and IDLE SHALL issue no writes; DONE holds until arm.
REQ-028 trig_cfg, trig_pos and decimator SHALL be sampled on arm and held for the whole capture.

Reset
REQ-029 While rst_n=0, all state clears immediately (asynchronous): FSM IDLE, synchronizers 0, tracker LOW, we=0, waddr=0, trig_addr=0, armed=0, triggered=0, capture_done=0.
REQ-030 Reset mid-capture SHALL discard the capture; after release the block stays in IDLE until arm.

Verification
REQ-031 decimator=0, trig_pos=4096, trig_cfg=00, arm, input LOW then HIGH after 5000 clocks -> trigger at the first HIGH write (synchronizer latency 3); capture_done after 4096 more writes; 9097 total writes.
REQ-032 Input LOW, MID x3, LOW, MID, HIGH during WAIT_TRIG with trig_cfg=00 -> exactly one trigger, on the HIGH sample.
REQ-033 Rising edge during PREFILL (trig_pos=8000, edge at sample 100) -> no trigger; the first rising edge after sample 192 triggers.
REQ-034 decimator=3 -> we every 8 clocks; waddr wraps 8191 -> 0; trig_pos=0, trig_cfg=11 -> DONE right after write 8192.
REQ-035 rst_n low during POST -> outputs clear within the same cycle; IDLE after release; no we until the next arm.
REQ-036 arm issued in DONE and again mid-POST -> restart in PREFILL with waddr=0 and triggered=0.
